// File: rtl/inmem_pkg.sv
// Shared register map, CTRL bit positions and byte-lane helper for the inmem probe/source block.
// The optional change-flag registers (ADDR_CHG0..3) only exist when INMEM_CHANGE_DETECT_EN is defined.
package inmem_pkg;

   localparam logic [3:0] ADDR_PROBE0 = 4'h0;
   localparam logic [3:0] ADDR_PROBE1 = 4'h1;
   localparam logic [3:0] ADDR_PROBE2 = 4'h2;
   localparam logic [3:0] ADDR_PROBE3 = 4'h3;
   localparam logic [3:0] ADDR_SRC_LO = 4'h4;
   localparam logic [3:0] ADDR_SRC_HI = 4'h5;
   localparam logic [3:0] ADDR_CTRL   = 4'h6;
   localparam logic [3:0] ADDR_ID     = 4'h7;
   localparam logic [3:0] ADDR_CHG0   = 4'h8;
   localparam logic [3:0] ADDR_CHG1   = 4'h9;
   localparam logic [3:0] ADDR_CHG2   = 4'hA;
   localparam logic [3:0] ADDR_CHG3   = 4'hB;

   localparam int CTRL_SNAP = 0;
   localparam int CTRL_AUTO = 1;

   localparam logic [7:0] DEFAULT_ID = 8'hA5;

   // Byte lane idx of a 32-bit word, lane 0 being the least significant.
   function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
      logic [7:0] result;
      result = '0;
      case (idx)
         2'd0:    result = word[7:0];
         2'd1:    result = word[15:8];
         2'd2:    result = word[23:16];
         default: result = word[31:24];
      endcase
      return result;
   endfunction

endpackage

// File: rtl/inmem_sync.sv
// Parameterized-width two-flop synchronizer; both stages clear to zero on reset.
module inmem_sync #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage1;

   always_ff @(posedge clk) begin
      if (reset) begin
         stage1 <= '0;
         q      <= '0;
      end else begin
         stage1 <= d;
         q      <= stage1;
      end
   end

endmodule

// File: rtl/inmem_probe_source.sv
// Debug probe/source register block: synchronized probe snapshot, writable source vector, byte host port.
// Optional per-bit sticky change flags at 0x8-0xB are built when INMEM_CHANGE_DETECT_EN is defined.
module inmem_probe_source
   import inmem_pkg::*;
#(
   parameter int                    PROBE_WIDTH  = 32,
   parameter int                    SOURCE_WIDTH = 10,
   parameter logic [SOURCE_WIDTH-1:0] SOURCE_INIT = '0,
   parameter logic [7:0]            ID_VALUE     = DEFAULT_ID
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [PROBE_WIDTH-1:0]  probe,
   output logic [SOURCE_WIDTH-1:0] source,
   input  logic [3:0]              host_addr,
   input  logic [7:0]              host_wdata,
   input  logic                    host_we,
   input  logic                    host_re,
   output logic [7:0]              host_rdata,
   output logic                    host_rvalid
);

   logic [PROBE_WIDTH-1:0]  sync2;
   logic [PROBE_WIDTH-1:0]  snapshot;
   logic                    auto_en;
   logic [31:0]             snap_word;
   logic [31:0]             chg_word;
   logic [15:0]             src_word;
   logic [SOURCE_WIDTH-1:0] src_next;
   logic                    wr_src_lo;
   logic                    wr_src_hi;
   logic                    wr_ctrl;
   logic                    snap_req;
   logic [7:0]              rd_mux;

   inmem_sync #(.WIDTH(PROBE_WIDTH)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (probe),
      .q     (sync2)
   );

   assign wr_src_lo = host_we && (host_addr == ADDR_SRC_LO);
   assign wr_src_hi = host_we && (host_addr == ADDR_SRC_HI);
   assign wr_ctrl   = host_we && (host_addr == ADDR_CTRL);
   assign snap_req  = wr_ctrl && host_wdata[CTRL_SNAP];

   // Zero-extend the narrow vectors so the read mux always works on full bytes.
   always_comb begin
      snap_word = '0;
      src_word  = '0;
      snap_word[PROBE_WIDTH-1:0]  = snapshot;
      src_word[SOURCE_WIDTH-1:0]  = source;
   end

   // Source bits above SOURCE_WIDTH simply have no flop, so high-byte writes to them vanish.
   always_comb begin
      src_next = source;
      for (int i = 0; i < SOURCE_WIDTH; i++) begin
         if ((i < 8) ? wr_src_lo : wr_src_hi) begin
            src_next[i] = host_wdata[i[2:0]];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         source   <= SOURCE_INIT;
         auto_en  <= 1'b1;
         snapshot <= '0;
      end else begin
         source <= src_next;
         if (wr_ctrl) begin
            auto_en <= host_wdata[CTRL_AUTO];
         end
         if (auto_en || snap_req) begin
            snapshot <= sync2;
         end
      end
   end

`ifdef INMEM_CHANGE_DETECT_EN
   logic [PROBE_WIDTH-1:0] sync2_prev;
   logic [PROBE_WIDTH-1:0] chg_flags;
   logic [PROBE_WIDTH-1:0] chg_set;
   logic [31:0]            clr_word;
   logic [2:0]             arm;

   always_comb begin
      clr_word = '0;
      if (host_we) begin
         case (host_addr)
            ADDR_CHG0: clr_word[7:0]   = host_wdata;
            ADDR_CHG1: clr_word[15:8]  = host_wdata;
            ADDR_CHG2: clr_word[23:16] = host_wdata;
            ADDR_CHG3: clr_word[31:24] = host_wdata;
            default:   clr_word = '0;
         endcase
      end
   end

   // arm[2] rises once sync2 and its previous value both hold real probe samples,
   // so the zero-to-first-sample step out of reset never raises a flag.
   assign chg_set = arm[2] ? (sync2 ^ sync2_prev) : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync2_prev <= '0;
         chg_flags  <= '0;
         arm        <= '0;
      end else begin
         sync2_prev <= sync2;
         arm        <= {arm[1:0], 1'b1};
         chg_flags  <= (chg_flags & ~clr_word[PROBE_WIDTH-1:0]) | chg_set;
      end
   end

   always_comb begin
      chg_word = '0;
      chg_word[PROBE_WIDTH-1:0] = chg_flags;
   end
`else
   assign chg_word = '0;
`endif

   // Reads sample pre-write state, so a same-cycle write at the read address is not visible yet.
   always_comb begin
      rd_mux = '0;
      case (host_addr)
         ADDR_PROBE0, ADDR_PROBE1, ADDR_PROBE2, ADDR_PROBE3:
            rd_mux = byte_sel(snap_word, host_addr[1:0]);
         ADDR_SRC_LO: rd_mux = src_word[7:0];
         ADDR_SRC_HI: rd_mux = src_word[15:8];
         ADDR_CTRL:   rd_mux[CTRL_AUTO] = auto_en;
         ADDR_ID:     rd_mux = ID_VALUE;
         ADDR_CHG0, ADDR_CHG1, ADDR_CHG2, ADDR_CHG3:
            rd_mux = byte_sel(chg_word, host_addr[1:0]);
         default:     rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         host_rdata  <= '0;
         host_rvalid <= 1'b0;
      end else begin
         host_rvalid <= host_re;
         if (host_re) begin
            host_rdata <= rd_mux;
         end
      end
   end

endmodule

// File: tb/tb_inmem_probe_source.sv
// Directed bench for inmem_probe_source: read results are scoreboarded and checked by a monitor.
// Change-flag steps run only when INMEM_CHANGE_DETECT_EN is defined.
module tb_inmem_probe_source;

   logic        clk;
   logic        reset;
   logic [31:0] probe;
   logic [9:0]  source;
   logic [3:0]  host_addr;
   logic [7:0]  host_wdata;
   logic        host_we;
   logic        host_re;
   logic [7:0]  host_rdata;
   logic        host_rvalid;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string      tag;
      logic [7:0] value;
   } exp_t;

   exp_t sb[$];

   inmem_probe_source #(
      .PROBE_WIDTH  (32),
      .SOURCE_WIDTH (10),
      .SOURCE_INIT  (10'h000),
      .ID_VALUE     (8'hA5)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .probe       (probe),
      .source      (source),
      .host_addr   (host_addr),
      .host_wdata  (host_wdata),
      .host_we     (host_we),
      .host_re     (host_re),
      .host_rdata  (host_rdata),
      .host_rvalid (host_rvalid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Every rvalid must match a queued read; a second rvalid cycle for one read shows up as unexpected.
   always @(negedge clk) begin
      exp_t e;
      if (host_rvalid) begin
         checks++;
         assert (sb.size() > 0) else begin
            errors++;
            $error("[TB] FAIL unexpected_rvalid observed=1 expected=0 rdata=%h", host_rdata);
         end
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput(e.tag, {24'h0, host_rdata}, {24'h0, e.value});
         end
      end
   end

   // Drives one cycle of host inputs starting at a falling edge.
   task automatic applyStimulus(input logic we, input logic re, input logic [3:0] addr, input logic [7:0] wdata);
      host_we    = we;
      host_re    = re;
      host_addr  = addr;
      host_wdata = wdata;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 4'h0, 8'h00);
   endtask

   task automatic readReg(input string tag, input logic [3:0] addr, input logic [7:0] expected);
      exp_t e;
      e.tag   = tag;
      e.value = expected;
      sb.push_back(e);
      applyStimulus(1'b0, 1'b1, addr, 8'h00);
   endtask

   task automatic writeReg(input logic [3:0] addr, input logic [7:0] data);
      applyStimulus(1'b1, 1'b0, addr, data);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset = 1'b1;
      probe = 32'h0;
      host_we = 1'b0; host_re = 1'b0; host_addr = 4'h0; host_wdata = 8'h00;
      @(negedge clk);
      @(negedge clk);
      checkOutput("rst_rvalid", {31'h0, host_rvalid}, 32'h0);
      checkOutput("rst_rdata", {24'h0, host_rdata}, 32'h0);
      checkOutput("rst_source", {22'h0, source}, 32'h0);
      reset = 1'b0;

      readReg("id", 4'h7, 8'hA5);
      idle(1);
      checkOutput("rvalid_one_cycle", {31'h0, host_rvalid}, 32'h0);
      checkOutput("rdata_hold", {24'h0, host_rdata}, 32'hA5);
      readReg("src_lo_rst", 4'h4, 8'h00);
      readReg("src_hi_rst", 4'h5, 8'h00);
      readReg("ctrl_rst", 4'h6, 8'h02);

      probe = 32'hDEADBEEF;
      idle(3);
      readReg("probe_b0", 4'h0, 8'hEF);
      readReg("probe_b1", 4'h1, 8'hBE);
      readReg("probe_b2", 4'h2, 8'hAD);
      readReg("probe_b3", 4'h3, 8'hDE);

      writeReg(4'h6, 8'h00);
      probe = 32'h12345678;
      idle(3);
      readReg("frozen_b0", 4'h0, 8'hEF);
      readReg("ctrl_auto_off", 4'h6, 8'h00);
      writeReg(4'h6, 8'h01);
      idle(1);
      readReg("snap_b0", 4'h0, 8'h78);
      readReg("snap_b1", 4'h1, 8'h56);
      readReg("snap_b2", 4'h2, 8'h34);
      readReg("snap_b3", 4'h3, 8'h12);
      readReg("snap_selfclear", 4'h6, 8'h00);

      writeReg(4'h4, 8'hFF);
      writeReg(4'h5, 8'hFF);
      checkOutput("source_all_ones", {22'h0, source}, 32'h3FF);
      readReg("src_hi_masked", 4'h5, 8'h03);
      readReg("src_lo_ff", 4'h4, 8'hFF);
      sb.push_back('{tag: "we_re_prewrite", value: 8'hFF});
      applyStimulus(1'b1, 1'b1, 4'h4, 8'h11);
      checkOutput("source_after_wr", {22'h0, source}, 32'h311);

      writeReg(4'hC, 8'h55);
      readReg("unmapped", 4'hC, 8'h00);
      writeReg(4'h7, 8'h00);
      readReg("id_ro", 4'h7, 8'hA5);
      writeReg(4'h0, 8'h00);
      readReg("probe_ro", 4'h0, 8'h78);
      idle(1);

      // Read strobe and reset on the same edge: the read must be dropped.
      reset = 1'b1;
      applyStimulus(1'b0, 1'b1, 4'h7, 8'h00);
      checkOutput("rst_mid_rvalid", {31'h0, host_rvalid}, 32'h0);
      checkOutput("rst_mid_source", {22'h0, source}, 32'h0);
      reset = 1'b0;
      readReg("rst_auto", 4'h6, 8'h02);
      readReg("rst_src_lo", 4'h4, 8'h00);
      idle(1);
      readReg("rst_auto_probe", 4'h0, 8'h78);

`ifdef INMEM_CHANGE_DETECT_EN
      idle(2);
      readReg("chg_none", 4'h8, 8'h00);
      readReg("chg_none_b3", 4'hB, 8'h00);
      probe = probe ^ 32'h1;
      idle(4);
      readReg("chg_set", 4'h8, 8'h01);
      readReg("chg_b1_clear", 4'h9, 8'h00);
      probe = probe ^ 32'h1;
      idle(2);
      writeReg(4'h8, 8'h01);
      readReg("chg_set_wins", 4'h8, 8'h01);
      writeReg(4'h8, 8'h01);
      readReg("chg_cleared", 4'h8, 8'h00);
`else
      writeReg(4'h8, 8'hFF);
      readReg("chg_absent", 4'h8, 8'h00);
`endif

      idle(3);
      checkOutput("sb_drained", sb.size(), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
